nmi_request_ctrl: RTL

- Initiator side of the core's non-maskable interrupt handshake (NMI, NMI_ID, NMI_ACK, RSM).
- Synchronises up to four asynchronous external event lines (push-buttons, DIP switches, peripheral strobes) and latches their rising edges as pending requests.
- Arbitrates the pending requests by fixed priority and presents one request at a time to the core.
- Closes each request with a one-cycle RSM pulse once service is reported complete.
- Sits in the top level beside the core; clocked by the core clock.

---
 rtl/nmi_request_ctrl_pkg.sv | 33 +++
 rtl/nmi_request_ctrl_sync_edge.sv | 41 ++++
 rtl/nmi_request_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/nmi_request_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nmi_request_ctrl_pkg
// Description : Shared constants, FSM encoding and the fixed-priority picker
//               for the NMI request controller.
// Revision    : 1.0 - initial release
// ============================================================================
package nmi_request_ctrl_pkg;

  // Four sources because the core's NMI_ID field is two bits wide.
  localparam int SRC_COUNT       = 4;
  localparam int ID_W            = 2;
  localparam int DEF_ACK_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2,
    ST_RESUME  = 2'd3
  } state_e;

  // Lowest set index wins; returns 0 when nothing is set (caller gates on |req).
  function automatic logic [ID_W-1:0] prio_pick(input logic [SRC_COUNT-1:0] req);
    logic [ID_W-1:0] pick;
    pick = '0;
    for (int i = SRC_COUNT - 1; i >= 0; i--) begin
      if (req[i]) pick = ID_W'(i);
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nmi_request_ctrl_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : nmi_sync_edge
// Description : Multi-flop synchroniser for one asynchronous event line plus
//               a registered rising-edge detector. One-cycle pulse per edge.
//               SYNC_STAGES must be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module nmi_sync_edge
  import nmi_request_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_q;

  // Shift the raw line through the synchroniser, remember the previous value
  // and register the edge so the detector output is glitch-free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign edge_o = edge_q;

endmodule
`default_nettype wire

// File: rtl/nmi_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nmi_request_ctrl
// Description : Initiator side of the core NMI handshake. Latches rising
//               edges of up to four async sources as pending requests,
//               arbitrates them by fixed priority (index 0 highest) and runs
//               the NMI / NMI_ACK / RSM four-phase handshake with an ACK
//               timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module nmi_request_ctrl
  import nmi_request_ctrl_pkg::*;
#(
  parameter int NUM_SRC     = SRC_COUNT,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int TMO_W       = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic [NUM_SRC-1:0] irq_mask_i,
  input  logic               svc_done_i,
  input  logic               nmi_ack_i,
  output logic               nmi_o,
  output logic [ID_W-1:0]    nmi_id_o,
  output logic               rsm_o,
  output logic [NUM_SRC-1:0] pending_o,
  output logic               busy_o,
  output logic               timeout_err_o
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(ACK_TIMEOUT);

  logic [NUM_SRC-1:0] edge_w;
  logic [NUM_SRC-1:0] set_w;
  logic [NUM_SRC-1:0] clr_w;
  logic [NUM_SRC-1:0] eligible_w;
  logic [ID_W-1:0]    winner_w;
  logic [TMO_W-1:0]   cnt_inc_w;

  logic [NUM_SRC-1:0] pending_q, pending_d;
  state_e             state_q;
  logic               nmi_q;
  logic [ID_W-1:0]    nmi_id_q;
  logic               rsm_q;
  logic               tmo_err_q;
  logic [TMO_W-1:0]   cnt_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      nmi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync_edge (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .src_i  (irq_src_i[gi]),
        .edge_o (edge_w[gi])
      );
    end
  endgenerate

  // Pending-set/clear arithmetic and arbitration; a new edge beats a clear.
  always_comb begin
    set_w      = edge_w & ~irq_mask_i;
    clr_w      = '0;
    if (state_q == ST_REQ && nmi_ack_i) begin
      clr_w = NUM_SRC'(1) << nmi_id_q;
    end
    pending_d  = (pending_q & ~clr_w) | set_w;
    eligible_w = pending_q & ~irq_mask_i;
    winner_w   = prio_pick(eligible_w);
    cnt_inc_w  = cnt_q + 1'b1;
  end

  // Sticky pending request register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Handshake FSM with registered NMI, NMI_ID, RSM and the timeout flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      nmi_q     <= 1'b0;
      nmi_id_q  <= '0;
      rsm_q     <= 1'b0;
      tmo_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      rsm_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|eligible_w) begin
            nmi_q    <= 1'b1;
            nmi_id_q <= winner_w;
            cnt_q    <= '0;
            state_q  <= ST_REQ;
          end
        end
        ST_REQ: begin
          cnt_q <= cnt_inc_w;
          // ACK takes precedence over a simultaneous timeout.
          if (nmi_ack_i) begin
            nmi_q   <= 1'b0;
            state_q <= ST_SERVICE;
          end else if (cnt_inc_w == TMO_LIMIT) begin
            nmi_q     <= 1'b0;
            tmo_err_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        ST_SERVICE: begin
          if (svc_done_i) begin
            rsm_q   <= 1'b1;
            state_q <= ST_RESUME;
          end
        end
        ST_RESUME: begin
          if (!nmi_ack_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign nmi_o         = nmi_q;
  assign nmi_id_o      = nmi_id_q;
  assign rsm_o         = rsm_q;
  assign pending_o     = pending_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign timeout_err_o = tmo_err_q;

endmodule
`default_nettype wire
